// File: rtl/reaction_sequencer.sv
// Reaction-time tester: random pre-delay, stimulus lamp, two-digit BCD timer in 10 ms units.
// Defining REACTION_BEST_SCORE_EN adds BestBCD1/BestBCD0 best-score outputs.

module reaction_sequencer #(
    parameter int DELAY_MIN = 100
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Pushn,
    input  logic       Tick,
    output logic       LEDn,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic       Busy,
    output logic       FalseStart,
    output logic       Overflow
`ifdef REACTION_BEST_SCORE_EN
    ,
    output logic [3:0] BestBCD1,
    output logic [3:0] BestBCD0
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        GO   = 3'd2,
        DONE = 3'd3,
        FOUL = 3'd4
    } state_t;

    localparam logic [8:0] DELAY_BASE = 9'(DELAY_MIN);

    state_t     state;
    logic [8:0] delay;
    logic [7:0] lfsr;
    logic       sync1;
    logic       sync2;
    logic       push_prev;
    logic       press;
    logic       at_max;

    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the values that existed before the clock edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            push_prev <= 1'b1;
        end else begin
            sync1     <= Pushn;
            sync2     <= sync1;
            push_prev <= sync2;
        end
    end

    // Falling edge of the synchronized button is the only press event.
    assign press = push_prev & ~sync2;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign at_max = (BCD1 == 4'd9) && (BCD0 == 4'd9);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            delay      <= 9'd0;
            BCD1       <= 4'd0;
            BCD0       <= 4'd0;
            LEDn       <= 1'b1;
            Busy       <= 1'b0;
            FalseStart <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FOUL: begin
                    if (Start) begin
                        state      <= WAIT;
                        delay      <= DELAY_BASE + {1'b0, lfsr};
                        BCD1       <= 4'd0;
                        BCD0       <= 4'd0;
                        Overflow   <= 1'b0;
                        FalseStart <= 1'b0;
                        Busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    // A press beats a terminal Tick arriving in the same cycle.
                    if (press) begin
                        state      <= FOUL;
                        Busy       <= 1'b0;
                        FalseStart <= 1'b1;
                    end else if (Tick) begin
                        if (delay <= 9'd1) begin
                            state <= GO;
                            delay <= 9'd0;
                            LEDn  <= 1'b0;
                        end else begin
                            delay <= delay - 9'd1;
                        end
                    end
                end
                GO: begin
                    if (press) begin
                        state <= DONE;
                        LEDn  <= 1'b1;
                        Busy  <= 1'b0;
                    end else if (Tick) begin
                        if (at_max) begin
                            state    <= DONE;
                            LEDn     <= 1'b1;
                            Busy     <= 1'b0;
                            Overflow <= 1'b1;
                        end else if (BCD0 == 4'd9) begin
                            BCD0 <= 4'd0;
                            BCD1 <= BCD1 + 4'd1;
                        end else begin
                            BCD0 <= BCD0 + 4'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    LEDn       <= 1'b1;
                    Busy       <= 1'b0;
                    FalseStart <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_SCORE_EN
    // Packed BCD digit pairs order the same way as the numbers they encode.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            BestBCD1 <= 4'd9;
            BestBCD0 <= 4'd9;
        end else if ((state == GO) && press && ({BCD1, BCD0} < {BestBCD1, BestBCD0})) begin
            BestBCD1 <= BCD1;
            BestBCD0 <= BCD0;
        end
    end
`endif

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: directed scenarios plus randomized trials
// checked cycle by cycle against an integer-level model of the trial rules.

module tb_reaction_sequencer;

    localparam int DMIN     = 3;
    localparam int TICK_PER = 5;
    localparam int BUDGET   = 2500;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start;
    logic       Pushn;
    logic       Tick;
    logic       LEDn;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
    logic       Busy;
    logic       FalseStart;
    logic       Overflow;
`ifdef REACTION_BEST_SCORE_EN
    logic [3:0] BestBCD1;
    logic [3:0] BestBCD0;
`endif

    reaction_sequencer #(.DELAY_MIN(DMIN)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Pushn      (Pushn),
        .Tick       (Tick),
        .LEDn       (LEDn),
        .BCD1       (BCD1),
        .BCD0       (BCD0),
        .Busy       (Busy),
        .FalseStart (FalseStart),
        .Overflow   (Overflow)
`ifdef REACTION_BEST_SCORE_EN
        ,
        .BestBCD1   (BestBCD1),
        .BestBCD0   (BestBCD0)
`endif
    );

    always #5 Clock = ~Clock;

    typedef enum int {M_IDLE, M_WAIT, M_GO, M_DONE, M_FOUL} phase_t;

    phase_t     m_phase;
    int         m_rem;
    int         m_count;
    int         m_best;
    bit         m_ovf;
    logic [7:0] m_lfsr;
    bit         pin_hist[$];

    int    tick_phase = 0;
    logic  pin_level  = 1'b1;
    int    n_checks   = 0;
    int    n_fail     = 0;
    int    trace_err  = 0;
    string first_err  = "";

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic model_reset();
        m_phase  = M_IDLE;
        m_rem    = 0;
        m_count  = 0;
        m_ovf    = 1'b0;
        m_best   = 99;
        m_lfsr   = 8'h01;
        pin_hist = '{1'b1, 1'b1, 1'b1};
    endtask

    // Model of one clock edge; pin_hist[k] is the pin level k+1 edges ago.
    task automatic model_edge(input logic st, input logic tk, input logic pin);
        bit press;
        press = !pin_hist[1] && pin_hist[2];
        case (m_phase)
            M_WAIT: begin
                if (press) m_phase = M_FOUL;
                else if (tk) begin
                    if (m_rem <= 1) m_phase = M_GO;
                    else m_rem--;
                end
            end
            M_GO: begin
                if (press) begin
                    m_phase = M_DONE;
                    if (m_count < m_best) m_best = m_count;
                end else if (tk) begin
                    if (m_count == 99) begin
                        m_ovf   = 1'b1;
                        m_phase = M_DONE;
                    end else begin
                        m_count++;
                    end
                end
            end
            default: begin
                if (st) begin
                    m_phase = M_WAIT;
                    m_rem   = DMIN + int'(m_lfsr);
                    m_count = 0;
                    m_ovf   = 1'b0;
                end
            end
        endcase
        m_lfsr = lfsr_next(m_lfsr);
        pin_hist.push_front(pin);
        void'(pin_hist.pop_back());
    endtask

    function automatic logic [11:0] expected_outputs();
        return {(m_phase != M_GO), 4'(m_count / 10), 4'(m_count % 10),
                (m_phase == M_WAIT || m_phase == M_GO), (m_phase == M_FOUL), m_ovf};
    endfunction

    // One clock cycle: drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic step(input logic st);
        logic [11:0] exp_v;
        logic [11:0] act_v;
        Start = st;
        Tick  = (tick_phase == 0);
        Pushn = pin_level;
        tick_phase = (tick_phase + 1) % TICK_PER;
        @(posedge Clock);
        model_edge(st, Tick, pin_level);
        @(negedge Clock);
        exp_v = expected_outputs();
        act_v = {LEDn, BCD1, BCD0, Busy, FalseStart, Overflow};
        if (act_v !== exp_v) begin
            if (trace_err == 0)
                first_err = $sformatf("t=%0t led_n/bcd1/bcd0/busy/fs/ovf got %h expected %h", $time, act_v, exp_v);
            trace_err++;
        end
`ifdef REACTION_BEST_SCORE_EN
        if ({BestBCD1, BestBCD0} !== {4'(m_best / 10), 4'(m_best % 10)}) begin
            if (trace_err == 0)
                first_err = $sformatf("t=%0t best got %h%h expected %0d", $time, BestBCD1, BestBCD0, m_best);
            trace_err++;
        end
`endif
        Start = 1'b0;
    endtask

    task automatic check_trace(input string name);
        n_checks++;
        if (trace_err !== 0) begin
            n_fail++;
            $display("FAIL trace_%s: %0d mismatching cycles, first %s", name, trace_err, first_err);
        end
        trace_err = 0;
    endtask

    // Runs an already-started trial to DONE/FOUL. press_n/press_p: press when the count is press_n
    // and the tick phase is press_p (-1 = never); foul_step: press on that WAIT cycle (-1 = never).
    task automatic finish_trial(input int press_n, input int press_p, input int foul_step,
                                input bit noise, input string name);
        int   steps;
        int   wait_steps;
        bit   done;
        logic st;
        steps = 0;
        wait_steps = 0;
        done = 1'b0;
        while (!done && steps < BUDGET) begin
            st = 1'b0;
            if (m_phase == M_WAIT) begin
                if (wait_steps == foul_step) pin_level = 1'b0;
                if (noise && wait_steps == 1) st = 1'b1;
                wait_steps++;
            end else if (m_phase == M_GO) begin
                if (press_n >= 0 && m_count == press_n && tick_phase == press_p) pin_level = 1'b0;
                if (noise && m_count == 3 && tick_phase == 2) st = 1'b1;
            end
            if (noise && $urandom_range(0, 19) == 0) st = 1'b1;
            step(st);
            steps++;
            done = (m_phase == M_DONE || m_phase == M_FOUL);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: trial still running after %0d cycles, required completion", name, steps);
        end
    endtask

    task automatic run_trial(input int press_n, input int press_p, input int foul_step,
                             input bit noise, input string name);
        pin_level = 1'b1;
        step(1'b1);
        finish_trial(press_n, press_p, foul_step, noise, name);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Start = 1'b0;
        Tick = 1'b0;
        pin_level = 1'b1;
        Pushn = 1'b1;
        #2 Resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Start = 1'b0;
        Tick = 1'b0;
        Pushn = 1'b1;
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #1;
        n_checks++;
        if ({LEDn, BCD1, BCD0, Busy, FalseStart, Overflow} !== {1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_values: got led_n=%b bcd=%h%h busy=%b fs=%b ovf=%b, expected 1 00 0 0 0",
                     LEDn, BCD1, BCD0, Busy, FalseStart, Overflow);
        end
`ifdef REACTION_BEST_SCORE_EN
        n_checks++;
        if ({BestBCD1, BestBCD0} !== 8'h99) begin
            n_fail++;
            $display("FAIL reset_best: got %h%h, expected 99", BestBCD1, BestBCD0);
        end
`endif
        model_reset();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_reaction_37();
        run_trial(37, 1, -1, 1'b0, "reaction_37");
        n_checks++;
        if ({BCD1, BCD0, Overflow, Busy, LEDn, FalseStart} !== {4'd3, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reaction_37: got bcd=%h%h ovf=%b busy=%b led_n=%b fs=%b, expected 37 0 0 1 0",
                     BCD1, BCD0, Overflow, Busy, LEDn, FalseStart);
        end
        check_trace("reaction_37");
    endtask

    task automatic test_false_start();
        run_trial(-1, 1, 2, 1'b0, "false_start");
        n_checks++;
        if ({FalseStart, LEDn, BCD1, BCD0, Busy} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL false_start: got fs=%b led_n=%b bcd=%h%h busy=%b, expected 1 1 00 0",
                     FalseStart, LEDn, BCD1, BCD0, Busy);
        end
        pin_level = 1'b1;
        step(1'b1);
        n_checks++;
        if ({FalseStart, Busy, LEDn} !== 3'b011) begin
            n_fail++;
            $display("FAIL restart_after_foul: got fs=%b busy=%b led_n=%b, expected 0 1 1", FalseStart, Busy, LEDn);
        end
        finish_trial(5, 2, -1, 1'b0, "after_foul");
        n_checks++;
        if ({BCD1, BCD0, FalseStart} !== {8'h05, 1'b0}) begin
            n_fail++;
            $display("FAIL after_foul_result: got bcd=%h%h fs=%b, expected 05 0", BCD1, BCD0, FalseStart);
        end
        check_trace("false_start");
    endtask

    task automatic test_overflow_back_to_back();
        run_trial(-1, 1, -1, 1'b0, "overflow");
        n_checks++;
        if ({BCD1, BCD0, Overflow, LEDn, Busy, FalseStart} !== {8'h99, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL overflow: got bcd=%h%h ovf=%b led_n=%b busy=%b fs=%b, expected 99 1 1 0 0",
                     BCD1, BCD0, Overflow, LEDn, Busy, FalseStart);
        end
        step(1'b1);
        n_checks++;
        if ({BCD1, BCD0, Overflow, Busy} !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL back_to_back_clear: got bcd=%h%h ovf=%b busy=%b, expected 00 0 1", BCD1, BCD0, Overflow, Busy);
        end
        finish_trial(7, 1, -1, 1'b0, "back_to_back");
        n_checks++;
        if ({BCD1, BCD0, Overflow} !== {8'h07, 1'b0}) begin
            n_fail++;
            $display("FAIL back_to_back_result: got bcd=%h%h ovf=%b, expected 07 0", BCD1, BCD0, Overflow);
        end
        check_trace("overflow");
    endtask

    task automatic test_press_on_tick();
        // Phase 3 places the press event on the same edge as the tick that would make 42.
        run_trial(41, 3, -1, 1'b0, "press_on_tick");
        n_checks++;
        if ({BCD1, BCD0, Overflow} !== {4'd4, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL press_on_tick: got bcd=%h%h ovf=%b, expected 41 0", BCD1, BCD0, Overflow);
        end
        check_trace("press_on_tick");
    endtask

    task automatic test_start_ignored();
        run_trial(10, 1, -1, 1'b1, "start_ignored");
        n_checks++;
        if ({BCD1, BCD0, Busy} !== {8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL start_ignored: got bcd=%h%h busy=%b, expected 10 0", BCD1, BCD0, Busy);
        end
        check_trace("start_ignored");
    endtask

    task automatic test_reset_mid_go();
        int steps;
        pin_level = 1'b1;
        step(1'b1);
        steps = 0;
        while (!(m_phase == M_GO && m_count == 20 && tick_phase == 2) && steps < BUDGET) begin
            step(1'b0);
            steps++;
        end
        n_checks++;
        if ({BCD1, BCD0, LEDn, Busy} !== {8'h20, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_go_state: got bcd=%h%h led_n=%b busy=%b, expected 20 0 1", BCD1, BCD0, LEDn, Busy);
        end
        #2 Resetn = 1'b0;
        #1;
        n_checks++;
        if ({LEDn, BCD1, BCD0, Busy, FalseStart, Overflow} !== {1'b1, 8'h00, 3'b000}) begin
            n_fail++;
            $display("FAIL async_reset: got led_n=%b bcd=%h%h busy=%b fs=%b ovf=%b, expected 1 00 0 0 0",
                     LEDn, BCD1, BCD0, Busy, FalseStart, Overflow);
        end
        model_reset();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) step(1'b0);
        run_trial(12, 2, -1, 1'b0, "after_reset");
        n_checks++;
        if ({BCD1, BCD0, Overflow} !== {8'h12, 1'b0}) begin
            n_fail++;
            $display("FAIL after_reset_result: got bcd=%h%h ovf=%b, expected 12 0", BCD1, BCD0, Overflow);
        end
        check_trace("reset_mid_go");
    endtask

    task automatic test_ignored_press();
        pin_level = 1'b1;
        repeat (4) step(1'b0);
        repeat (3) begin
            pin_level = 1'b0;
            repeat (4) step(1'b0);
            pin_level = 1'b1;
            repeat (4) step(1'b0);
        end
        n_checks++;
        if ({BCD1, BCD0, Busy, FalseStart} !== {8'h12, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignored_press: got bcd=%h%h busy=%b fs=%b, expected 12 0 0", BCD1, BCD0, Busy, FalseStart);
        end
        check_trace("ignored_press");
    endtask

    task automatic test_random();
        int press_n;
        int press_p;
        int foul_step;
        for (int i = 0; i < 6; i++) begin
            press_n   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 98));
            press_p   = int'($urandom_range(1, 4));
            foul_step = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
            pin_level = 1'b1;
            repeat ($urandom_range(0, 7)) step(1'b0);
            run_trial(press_n, press_p, foul_step, 1'b1, "random");
            n_checks++;
            if ({BCD1, BCD0, Overflow, FalseStart} !==
                {4'(m_count / 10), 4'(m_count % 10), m_ovf, (m_phase == M_FOUL)}) begin
                n_fail++;
                $display("FAIL random_result_%0d: got bcd=%h%h ovf=%b fs=%b, expected count %0d ovf=%b foul=%b",
                         i, BCD1, BCD0, Overflow, FalseStart, m_count, m_ovf, (m_phase == M_FOUL));
            end
            check_trace($sformatf("random_%0d", i));
        end
    endtask

`ifdef REACTION_BEST_SCORE_EN
    task automatic test_best();
        do_reset();
        run_trial(45, 1, -1, 1'b0, "best_45");
        run_trial(30, 1, -1, 1'b0, "best_30");
        run_trial(50, 1, -1, 1'b0, "best_50");
        n_checks++;
        if ({BestBCD1, BestBCD0} !== 8'h30) begin
            n_fail++;
            $display("FAIL best_after_results: got %h%h, expected 30", BestBCD1, BestBCD0);
        end
        run_trial(-1, 1, 2, 1'b0, "best_foul");
        run_trial(-1, 1, -1, 1'b0, "best_overflow");
        n_checks++;
        if ({BestBCD1, BestBCD0} !== 8'h30) begin
            n_fail++;
            $display("FAIL best_after_foul_overflow: got %h%h, expected 30", BestBCD1, BestBCD0);
        end
        check_trace("best");
    endtask
`endif

    initial begin
        test_reset();
        test_reaction_37();
        test_false_start();
        test_overflow_back_to_back();
        test_press_on_tick();
        test_start_ignored();
        test_reset_mid_go();
        test_ignored_press();
        test_random();
`ifdef REACTION_BEST_SCORE_EN
        test_best();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
